// File: rtl/data_sram_responder.sv
// Data-SRAM responder: one-cycle read-first RAM plus a small configuration
// register window (LED, switch, free-running timer, scratch).
module data_sram_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
  parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led
);

  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH = 16'h000c;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       timer;
  logic [31:0]       scratch;
  logic [31:0]       conf_rdata;
  logic [15:0]       offset;
  logic [ADDR_W-1:0] word_idx;
  logic              access;
  logic              conf_hit;
  logic              conf_wr;
  logic              ram_we;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
    return res;
  endfunction

  // An access coinciding with reset is dropped entirely.
  assign access   = data_sram_en && !reset;
  assign conf_hit = ((data_sram_addr & CONF_MASK) == CONF_BASE);
  assign offset   = {data_sram_addr[15:2], 2'b00};
  assign word_idx = data_sram_addr[ADDR_W+1:2];
  assign conf_wr  = access && conf_hit && (data_sram_wen != 4'b0000);
  assign ram_we   = access && !conf_hit && (data_sram_wen != 4'b0000);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    conf_rdata = 32'd0;
    case (offset)
      OFF_LED:     conf_rdata = {16'd0, led};
      OFF_SWITCH:  conf_rdata = {24'd0, switch};
      OFF_TIMER:   conf_rdata = timer;
      OFF_SCRATCH: conf_rdata = scratch;
      default:     conf_rdata = 32'd0;
    endcase
  end

  // NOTE: the RAM array has no reset; clearing it would prevent block-RAM
  // mapping, and its contents are undefined until written anyway.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; this is what makes reads return the old word.
  always_ff @(posedge clk) begin
    if (reset)
      data_sram_rdata <= 32'd0;
    else if (data_sram_en)
      data_sram_rdata <= conf_hit ? conf_rdata : mem[word_idx];
  end

  always_ff @(posedge clk) begin
    if (reset)
      led <= 16'd0;
    else if (conf_wr && offset == OFF_LED) begin
      if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
      if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
    end
  end

  // A load replaces the increment for that cycle.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= 32'd0;
    else if (conf_wr && offset == OFF_TIMER)
      timer <= byte_merge(timer, data_sram_wdata, data_sram_wen);
    else
      timer <= timer + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      scratch <= 32'd0;
    else if (conf_wr && offset == OFF_SCRATCH)
      scratch <= byte_merge(scratch, data_sram_wdata, data_sram_wen);
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table plus randomized traffic
// checked against a transaction-level model of the responder.
module tb_data_sram_responder;

  localparam int          ADDR_W    = 10;
  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] CONF_BASE = 32'hbfaf_0000;
  localparam logic [31:0] CONF_MASK = 32'hffff_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;

  int total = 0;
  int bad   = 0;

  data_sram_responder #(
    .ADDR_W(ADDR_W), .CONF_BASE(CONF_BASE), .CONF_MASK(CONF_MASK)
  ) dut (
    .clk(clk), .reset(reset),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .switch(switch), .led(led)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata;
  logic        m_known;
  logic        m_valid = 1'b0;
  logic [15:0] m_led;
  logic [31:0] m_timer;
  logic [31:0] m_scratch;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] apply_bytes(input logic [31:0] cur, input logic [31:0] nxt,
                                              input logic [3:0] be);
    logic [31:0] r = cur;
    for (int b = 0; b < 4; b++)
      if (be[b]) r = (r & ~(32'hff << (8*b))) | (nxt & (32'hff << (8*b)));
    return r;
  endfunction

  // Transaction-level effect of one clock edge.
  task automatic model_edge(input logic rst, input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] sw);
    logic [31:0] next_timer;
    int          idx;
    int          off;
    if (rst) begin
      m_rdata = 0; m_known = 1; m_led = 0; m_timer = 0; m_scratch = 0; m_valid = 1;
      return;
    end
    next_timer = m_timer + 1;
    if (en) begin
      if ((addr & CONF_MASK) == CONF_BASE) begin
        off = int'(addr % 65536) / 4 * 4;
        m_known = 1;
        case (off)
          0: begin
            m_rdata = {16'd0, m_led};
            m_led = 16'(apply_bytes({16'd0, m_led}, wdata, wen & 4'b0011));
          end
          4: m_rdata = {24'd0, sw};
          8: begin
            m_rdata = m_timer;
            if (wen != 0) next_timer = apply_bytes(m_timer, wdata, wen);
          end
          12: begin
            m_rdata = m_scratch;
            m_scratch = apply_bytes(m_scratch, wdata, wen);
          end
          default: m_rdata = 0;
        endcase
      end else begin
        idx = int'((addr / 4) % DEPTH);
        m_known = m_mem.exists(idx);
        if (m_known) m_rdata = m_mem[idx];
        if (wen == 4'hf) m_mem[idx] = wdata;
        else if (wen != 0 && m_mem.exists(idx)) m_mem[idx] = apply_bytes(m_mem[idx], wdata, wen);
      end
    end
    m_timer = next_timer;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input logic rst, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] sw);
    reset = rst; data_sram_en = en; data_sram_wen = wen;
    data_sram_addr = addr; data_sram_wdata = wdata; switch = sw;
    @(posedge clk);
    #1;
    model_edge(rst, en, wen, addr, wdata, sw);
    if (m_valid) begin
      check("led", {16'd0, led}, {16'd0, m_led});
      if (m_known) check("rdata", data_sram_rdata, m_rdata);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] sw, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.rst = rst; v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.sw = sw; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0]  r_wen;
    logic [31:0] r_addr;

    // rst en wen addr wdata sw chk expected-rdata
    add(1, 0, 4'h0, 32'h0,             32'h0,         8'h00, 1, 32'h0);
    add(0, 1, 4'hf, 32'h0000_0010,     32'h1234_5678, 8'h00, 0, 32'h0);
    add(0, 1, 4'h0, 32'h0000_0010,     32'h0,         8'h00, 1, 32'h1234_5678);
    add(0, 1, 4'h4, 32'h0000_0010,     32'hAABB_CCDD, 8'h00, 1, 32'h1234_5678);
    add(0, 1, 4'h0, 32'h0000_0010,     32'h0,         8'h00, 1, 32'h12BB_5678);
    add(0, 1, 4'h0, 32'h0000_1010,     32'h0,         8'h00, 1, 32'h12BB_5678);
    add(0, 1, 4'hf, 32'h0000_0020,     32'h1111_1111, 8'h00, 0, 32'h0);
    add(0, 1, 4'hf, 32'h0000_0020,     32'h2222_2222, 8'h00, 1, 32'h1111_1111);
    add(0, 1, 4'h0, 32'h0000_0020,     32'h0,         8'h00, 1, 32'h2222_2222);
    add(0, 1, 4'hf, CONF_BASE + 32'h0, 32'hFFFF_A5A5, 8'h00, 1, 32'h0);
    add(0, 1, 4'h0, CONF_BASE + 32'h0, 32'h0,         8'h00, 1, 32'h0000_A5A5);
    add(0, 1, 4'h0, CONF_BASE + 32'h4, 32'h0,         8'h3C, 1, 32'h0000_003C);
    add(0, 1, 4'h0, CONF_BASE + 32'h10, 32'h0,        8'h3C, 1, 32'h0);
    add(0, 1, 4'hf, CONF_BASE + 32'h8, 32'hFFFF_FFFE, 8'h00, 0, 32'h0);
    add(0, 0, 4'h0, 32'h0,             32'h0,         8'h00, 0, 32'h0);
    add(0, 1, 4'h0, CONF_BASE + 32'h8, 32'h0,         8'h00, 1, 32'hFFFF_FFFF);
    add(0, 1, 4'h0, CONF_BASE + 32'h8, 32'h0,         8'h00, 1, 32'h0000_0000);
    add(0, 1, 4'h1, CONF_BASE + 32'h8, 32'h0000_0055, 8'h00, 1, 32'h0000_0001);
    add(0, 1, 4'h0, CONF_BASE + 32'h8, 32'h0,         8'h00, 1, 32'h0000_0055);
    add(0, 1, 4'hf, CONF_BASE + 32'hC, 32'hDEAD_BEEF, 8'h00, 1, 32'h0);
    add(0, 1, 4'h0, CONF_BASE + 32'hC, 32'h0,         8'h00, 1, 32'hDEAD_BEEF);
    add(0, 1, 4'hf, 32'h0000_0030,     32'hCAFE_F00D, 8'h00, 0, 32'h0);
    add(1, 1, 4'hf, 32'h0000_0030,     32'h0BAD_0BAD, 8'h00, 1, 32'h0);
    add(0, 1, 4'h0, CONF_BASE + 32'h0, 32'h0,         8'h00, 1, 32'h0);
    add(0, 1, 4'h0, CONF_BASE + 32'h8, 32'h0,         8'h00, 1, 32'h0000_0001);
    add(0, 1, 4'h0, CONF_BASE + 32'hC, 32'h0,         8'h00, 1, 32'h0);
    add(0, 1, 4'h0, 32'h0000_0030,     32'h0,         8'h00, 1, 32'hCAFE_F00D);
    add(0, 0, 4'hf, 32'h0000_0030,     32'h0,         8'h00, 1, 32'hCAFE_F00D);
    add(0, 1, 4'h0, 32'h0000_0030,     32'h0,         8'h00, 1, 32'hCAFE_F00D);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].sw);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), data_sram_rdata, vecs[i].exp);
    end
    check("led_after_reset", {16'd0, led}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      r_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        r_addr = CONF_BASE + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      else
        r_addr = 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3) << 12)
               + 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, r_wen, r_addr,
            $urandom, 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
